// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM state encoding, error codes, memory geometry.
// Imported by imem_loader; optional checksum build is IMEM_LOADER_CSUM_EN.
package imem_loader_pkg;

  localparam int DEF_MEM_DEPTH = 2048;
  localparam int DEF_ADDR_W    = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_LOAD,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing Y86 program bytes into the imem write port.
// Ports: clk, rst_n, start, base_addr, in_valid/in_data/in_ready, wr_en/wr_addr/
// wr_data, busy, done, err, err_code, byte_count. Macro: IMEM_LOADER_CSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [63:0]       base_addr,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [11:0]       byte_count
);

  state_e            state_q, state_d;
  logic [63:0]       base_q, base_d;
  logic [7:0]        lo_q, lo_d;
  logic [15:0]       len_q, len_d;
  logic [11:0]       cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        acc;
  logic [15:0] n;
  logic        rng_bad;
  logic        last;

  assign acc = in_valid && rdy_q;
  assign n   = {in_data, lo_q};

  // Fail when the base is past the array or the frame would run off its end;
  // this also rules out any address wrap inside a load.
  assign rng_bad = (base_q >= 64'(MEM_DEPTH)) ||
                   (64'(n) > (64'(MEM_DEPTH) - base_q));

  assign last = (({4'b0, cnt_q} + 16'd1) == len_q);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    lo_d      = lo_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    err_d     = err_q;
    code_d    = code_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_LO;
          base_d  = base_addr;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (acc) begin
          lo_d    = in_data;
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (acc) begin
          len_d = n;
          if (rng_bad) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = ERR_RANGE;
          end else if (n == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (acc) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q[ADDR_W-1:0] + cnt_q[ADDR_W-1:0];
          wr_data_d = in_data;
          cnt_d     = cnt_q + 12'd1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d    = csum_q ^ in_data;
          if (last) state_d = S_CSUM;
`else
          if (last) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
`endif
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM: begin
        if (acc) begin
          if (in_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = ERR_CSUM;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    rdy_d  = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
             (state_d == S_LOAD)   || (state_d == S_CSUM);
    busy_d = rdy_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      lo_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      lo_q      <= lo_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign in_ready   = rdy_q;
  assign busy       = busy_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign byte_count = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus random frames
// compared against a frame-level model of expected writes and status.
module tb_imem_loader;

`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] base_addr;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [11:0] byte_count;

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  pay_q[$];

  always @(negedge clk)
    if (wr_en) got_q.push_back({8'h0, 32'(cyc), 5'b0, wr_addr, wr_data});

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_load(input string tag, input logic [63:0] base,
                          input logic [15:0] n, input bit bad_csum,
                          input int mode, input bit glitch);
    logic [7:0] stream[$];
    logic [7:0] x;
    bit         range_bad;
    logic [1:0] exp_code;
    int         idx;
    int         guard;
    bit         v;
    x = 8'h0;
    idx = 0;
    guard = 0;
    range_bad = (base >= 64'd2048) || (64'(n) > 64'd2048 - base);
    if (range_bad) pay_q.delete();
    else while (pay_q.size() < int'(n)) pay_q.push_back(8'($urandom));
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    foreach (pay_q[i]) begin
      stream.push_back(pay_q[i]);
      x ^= pay_q[i];
    end
    if (CSUM) stream.push_back(bad_csum ? (x ^ 8'h07) : x);
    exp_code = range_bad ? 2'd1 : ((CSUM && bad_csum) ? 2'd2 : 2'd0);
    got_q.delete();
    exp_q.delete();
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    @(negedge clk);
    start = 1'b0;
    check({tag, " rdy"}, in_ready, 1);
    check({tag, " busy"}, busy, 1);
    if (glitch) begin
      start = 1'b1;
      base_addr = {$urandom, $urandom};
      @(negedge clk);
      start = 1'b0;
    end
    while (idx < stream.size()) begin
      if (!in_ready) break;
      case (mode)
        0: v = 1'b1;
        1: v = (guard % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_valid = v;
      in_data = stream[idx];
      if (v && idx >= 2 && idx < 2 + int'(n) && !range_bad)
        exp_q.push_back({8'h0, 32'(cyc + 1), 5'b0,
                         11'(base + 64'(idx - 2)), stream[idx]});
      @(negedge clk);
      if (v) idx++;
      guard++;
      if (guard > 20000) begin
        check({tag, " stall"}, idx, stream.size());
        break;
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8 && !(done || err); i++) @(negedge clk);
    #1;
    check({tag, " done"}, done, exp_code == 2'd0);
    check({tag, " err"}, err, exp_code != 2'd0);
    check({tag, " code"}, err_code, exp_code);
    check({tag, " cnt"}, byte_count, range_bad ? 0 : n);
    check({tag, " idle_rdy"}, in_ready, 0);
    check({tag, " idle_busy"}, busy, 0);
    check({tag, " nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s wr%0d", tag, i), got_q[i], exp_q[i]);
    pay_q.delete();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " rdy"}, in_ready, 0);
    check({tag, " wr_en"}, wr_en, 0);
    check({tag, " wr_addr"}, wr_addr, 0);
    check({tag, " wr_data"}, wr_data, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err"}, err, 0);
    check({tag, " code"}, err_code, 0);
    check({tag, " cnt"}, byte_count, 0);
  endtask

  initial begin
    logic [63:0] b;
    logic [15:0] n;
    int          kind;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    in_valid = 1'b0;
    in_data = '0;
    #12;
    check_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    pay_q = '{8'h30, 8'hF8, 8'h08};
    run_load("basic", 64'd0, 16'd3, 1'b0, 0, 1'b0);
    run_load("rng_over", 64'd2040, 16'd9, 1'b0, 0, 1'b0);
    run_load("rng_edge", 64'd2039, 16'd9, 1'b0, 0, 1'b0);
    run_load("zero_len", 64'd500, 16'd0, 1'b0, 0, 1'b0);
    pay_q = '{8'h30, 8'h00, 8'h90};
    run_load("toggle", 64'd16, 16'd3, 1'b0, 1, 1'b1);
    pay_q = '{8'h01, 8'h02};
    run_load("csum_ok", 64'd40, 16'd2, 1'b0, 0, 1'b0);
    pay_q = '{8'h01, 8'h02};
    run_load("csum_bad", 64'd40, 16'd2, 1'b1, 0, 1'b0);
    run_load("big_base", 64'h1_0000_0000, 16'd1, 1'b0, 0, 1'b0);

    @(negedge clk);
    start = 1'b1;
    base_addr = 64'd100;
    @(negedge clk);
    start = 1'b0;
    foreach (pay_q[i]) pay_q.delete();
    pay_q = '{8'h05, 8'h00, 8'hAA, 8'hBB};
    foreach (pay_q[i]) begin
      in_valid = 1'b1;
      in_data = pay_q[i];
      @(negedge clk);
    end
    pay_q.delete();
    check("mid pend_wr", wr_en, 1);
    check("mid pend_addr", wr_addr, 101);
    check("mid pend_data", wr_data, 8'hBB);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outs("post_rst");
    run_load("reload", 64'd100, 16'd5, 1'b0, 2, 1'b0);

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin b = 64'($urandom_range(0, 2047)); n = 16'($urandom_range(0, 10)); end
        1: begin b = 64'(2048 - $urandom_range(1, 12)); n = 16'($urandom_range(0, 14)); end
        2: begin b = {$urandom, $urandom} | 64'h800; n = 16'($urandom_range(0, 6)); end
        default: begin b = 64'($urandom_range(0, 2047)); n = 16'($urandom); end
      endcase
      run_load($sformatf("rnd%0d", t), b, n, ($urandom_range(0, 3) == 0),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer-side counterpart of the fetch-stage instruction memory: loads Y86 program bytes into the 2048-byte instruction memory array through its write port. Accepts a framed byte stream over a valid/ready handshake, range-checks the frame against memory depth, and issues one registered byte write per accepted payload byte. Sits between the host/testbench program source and the instruction memory; the fetch stage is held off while `busy` is high.

## Interface
- `MEM_DEPTH`, 2048, instruction memory size in bytes
- `ADDR_W`, 11, write address width (log2 of MEM_DEPTH)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a new load; sampled in IDLE/DONE/ERR only
- `base_addr`  in  64  first write address, same width as `pc`; captured on `start`
- `in_valid`  in  1  stream byte valid
- `in_data`  in  8  stream byte
- `in_ready`  out  1  loader accepts byte this cycle
- `wr_en`  out  1  memory write strobe
- `wr_addr`  out  ADDR_W  memory write address
- `wr_data`  out  8  memory write byte
- `busy`  out  1  load in progress
- `done`  out  1  load completed successfully (level)
- `err`  out  1  load failed (level)
- `err_code`  out  2  0 none, 1 range, 2 checksum
- `byte_count`  out  12  payload bytes written in current load

## Operation
- Frame: LEN_LO, LEN_HI (16-bit little-endian length N), N payload bytes, then one checksum byte when enabled.
- States: IDLE, LEN_LO, LEN_HI, LOAD, CSUM, DONE, ERR.
- IDLE/DONE/ERR + `start` -> LEN_LO; capture `base_addr`, clear `byte_count`, `done`, `err`, `err_code`, checksum accumulator.
- LEN_LO: accept byte -> LEN_HI.
- LEN_HI: accept byte, form N; range check `base_addr >= MEM_DEPTH` or `N > MEM_DEPTH - base_addr` -> ERR code 1 (no writes issued); else N == 0 -> CSUM if enabled, else DONE; else -> LOAD.
- LOAD: each accepted byte k (0-based) writes address `base_addr + k` (low ADDR_W bits), XORs into accumulator, increments `byte_count`; after byte N-1 -> CSUM if enabled, else DONE.
- CSUM: accept one byte; equal to accumulator -> DONE, else ERR code 2. Payload already written stays written.
- `in_ready` = 1 only in LEN_LO, LEN_HI, LOAD, CSUM; byte transfers when `in_valid && in_ready`.
- `busy` = 1 in LEN_LO..CSUM.
- `start` while busy: ignored.
- Range check guarantees no address wrap; 16-bit N > 2048 always fails.

## Timing
- Reset: state IDLE; `in_ready`, `wr_en`, `busy`, `done`, `err` = 0; `err_code` = 0; `wr_addr`, `wr_data`, `byte_count` = 0.
- `start` at edge t: `in_ready` high from t+1.
- Write latency: byte accepted at edge t -> `wr_en`, `wr_addr`, `wr_data` registered, valid during cycle after t, one cycle wide; back-to-back bytes give back-to-back writes (1 byte/cycle).
- `byte_count` updates with the same edge as `wr_en` assertion.
- `done`/`err` assert the edge after the final accepted byte (last payload, checksum, or LEN_HI on range/zero-length) and hold until next `start` or reset.
- `in_valid` low stalls indefinitely; no timeout.
- Reset mid-load: immediate return to IDLE, pending write dropped; already-written bytes remain in memory.

## Configuration
- `IMEM_LOADER_CSUM_EN`: defined -> trailing XOR checksum byte expected, CSUM state present, `err_code` 2 reachable. Undefined -> no checksum byte, CSUM state and accumulator omitted, LOAD/zero-length go straight to DONE, `err_code` never 2.

## Structure
- Shared package: state enum, `err_code` constants (ERR_NONE, ERR_RANGE, ERR_CSUM), `MEM_DEPTH` default, memory address width.
- Single module; no sub-module needed. The memory array and its write port live in the instruction memory block, not here.

## Test plan
- Base 0, N=3, bytes 0x30,0xF8,0x08, continuous valid -> writes addr 0,1,2 with those bytes on consecutive cycles, `done`=1, `byte_count`=3.
- Base 2040, N=9 -> `err`=1, `err_code`=1, zero `wr_en` pulses; base 2039, N=9 -> writes 2039..2047, `done`=1.
- N=0 -> no writes, `done`=1 (with CSUM_EN: checksum byte 0x00 required).
- Payload 0x30,0x00,0x90 with valid toggled every other cycle -> 3 writes, each one cycle after its acceptance, no drops or duplicates.
- CSUM_EN, payload 0x01,0x02, checksum 0x03 -> `done`; checksum 0x04 -> `err_code`=2, both bytes written.
- `rst_n` low after 2 of 5 payload bytes -> outputs at reset values, state IDLE; new `start` loads cleanly.
